// File: rtl/quick_add_round.sv
// Two-player mental-arithmetic game: draws two 7-bit operands from an LFSR,
// lets an external adder produce the reference sum, and scores the first correct guess.
module quick_add_round #(
    parameter int unsigned WIN_SCORE = 5,
    parameter int unsigned TIMEOUT   = 1000,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       go1,
    input  logic       go2,
    input  logic [7:0] guess1,
    input  logic [7:0] guess2,
    input  logic [7:0] sum_in,
    input  logic       cout_in,
    output logic [7:0] op_a,
    output logic [7:0] op_b,
    output logic       op_cin,
    output logic       round_active,
    output logic       lock1,
    output logic       lock2,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic       result_valid,
    output logic [1:0] winner,
    output logic       err,
    output logic       game_over
);

    localparam int unsigned   TW         = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [3:0]    WIN        = 4'(WIN_SCORE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_RESULT,
        S_GAMEOVER
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [15:0]   lfsr;
    logic [TW-1:0] timer;
    logic          ok1;
    logic          ok2;
    logic          lock1_nxt;
    logic          lock2_nxt;
    logic          inc1;
    logic          inc2;
    logic [1:0]    win_code;

    // A player who is already locked out cannot score or re-lock.
    assign ok1       = go1 && !lock1 && (guess1 == sum_in);
    assign ok2       = go2 && !lock2 && (guess2 == sum_in);
    assign lock1_nxt = lock1 || (go1 && (guess1 != sum_in));
    assign lock2_nxt = lock2 || (go2 && (guess2 != sum_in));

    assign op_cin       = 1'b0;
    assign round_active = (state == S_WAIT);
    assign result_valid = (state == S_RESULT);
    assign game_over    = (state == S_GAMEOVER);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // An adder carry is treated as a fault and outranks any guess; a correct
    // guess outranks lockout and timeout.
    always_comb begin
        state_nxt = state;
        win_code  = 2'b00;
        inc1      = 1'b0;
        inc2      = 1'b0;
        case (state)
            S_IDLE:     if (start) state_nxt = S_LOAD;
            S_LOAD:     state_nxt = S_WAIT;
            S_WAIT: begin
                if (cout_in) begin
                    state_nxt = S_RESULT;
                end else if (ok1 && ok2) begin
                    win_code  = 2'b11;
                    state_nxt = S_RESULT;
                end else if (ok1) begin
                    win_code  = 2'b01;
                    inc1      = 1'b1;
                    state_nxt = S_RESULT;
                end else if (ok2) begin
                    win_code  = 2'b10;
                    inc2      = 1'b1;
                    state_nxt = S_RESULT;
                end else if ((lock1_nxt && lock2_nxt) || (timer == TIMER_LAST)) begin
                    state_nxt = S_RESULT;
                end
            end
            S_RESULT:   state_nxt = ((score1 == WIN) || (score2 == WIN)) ? S_GAMEOVER : S_IDLE;
            S_GAMEOVER: if (start) state_nxt = S_LOAD;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr   <= SEED;
            op_a   <= 8'h00;
            op_b   <= 8'h00;
            lock1  <= 1'b0;
            lock2  <= 1'b0;
            timer  <= '0;
            err    <= 1'b0;
            winner <= 2'b00;
            score1 <= 4'd0;
            score2 <= 4'd0;
        end else begin
            case (state)
                S_LOAD: begin
                    op_a   <= {1'b0, lfsr[6:0]};
                    op_b   <= {1'b0, lfsr[14:8]};
                    lfsr   <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
                    lock1  <= 1'b0;
                    lock2  <= 1'b0;
                    timer  <= '0;
                    err    <= 1'b0;
                    winner <= 2'b00;
                end
                S_WAIT: begin
                    timer <= timer + 1'b1;
                    lock1 <= lock1_nxt;
                    lock2 <= lock2_nxt;
                    if (cout_in) err <= 1'b1;
                    if (state_nxt == S_RESULT) winner <= win_code;
                    if (inc1 && (score1 != WIN)) score1 <= score1 + 4'd1;
                    if (inc2 && (score2 != WIN)) score2 <= score2 + 4'd1;
                end
                S_GAMEOVER: begin
                    if (start) begin
                        score1 <= 4'd0;
                        score2 <= 4'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_quick_add_round.sv
// Directed bench for quick_add_round with a small game (WIN_SCORE=2, TIMEOUT=4)
// and a behavioural 8-bit adder closing the operand/sum loop.
module tb_quick_add_round;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, go1, go2, force_cout;
    logic [7:0] guess1, guess2, sum_in;
    logic       cout_in, adder_cout;
    logic [7:0] op_a, op_b;
    logic       op_cin, round_active, lock1, lock2, result_valid, err, game_over;
    logic [3:0] score1, score2;
    logic [1:0] winner;
    int         checks = 0;
    int         fails  = 0;

    always #5 clk = ~clk;

    assign {adder_cout, sum_in} = {1'b0, op_a} + {1'b0, op_b} + {8'h00, op_cin};
    assign cout_in = adder_cout | force_cout;

    quick_add_round #(.WIN_SCORE(2), .TIMEOUT(4), .SEED(16'hACE1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .go1(go1), .go2(go2),
        .guess1(guess1), .guess2(guess2), .sum_in(sum_in), .cout_in(cout_in),
        .op_a(op_a), .op_b(op_b), .op_cin(op_cin), .round_active(round_active),
        .lock1(lock1), .lock2(lock2), .score1(score1), .score2(score2),
        .result_valid(result_valid), .winner(winner), .err(err), .game_over(game_over)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // IDLE -> LOAD -> WAIT; returns in the first WAIT cycle.
    task automatic start_round();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; go1 = 1'b0; go2 = 1'b0; force_cout = 1'b0;
        guess1 = 8'h00; guess2 = 8'h00;
        repeat (2) tick();
        checks++;
        if ({op_a, op_b, op_cin} !== 17'h0) begin
            fails++; $display("FAIL reset_ops: got %h/%h/%b want 00/00/0", op_a, op_b, op_cin);
        end
        checks++;
        if ({score1, score2} !== 8'h00) begin
            fails++; $display("FAIL reset_scores: got %0d/%0d want 0/0", score1, score2);
        end
        checks++;
        if ({lock1, lock2, winner, err, result_valid, round_active, game_over} !== 8'h00) begin
            fails++; $display("FAIL reset_flags: got %b want 00000000",
                              {lock1, lock2, winner, err, result_valid, round_active, game_over});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_p1_win();
        start_round();
        checks++;
        if ({round_active, op_a, op_b} !== {1'b1, 8'h61, 8'h2C}) begin
            fails++; $display("FAIL p1_ops: got act=%b %h/%h want 1 61/2C", round_active, op_a, op_b);
        end
        go1 = 1'b1; guess1 = 8'h8D;
        tick();
        go1 = 1'b0;
        checks++;
        if ({result_valid, winner, score1, score2, round_active} !== {1'b1, 2'b01, 4'd1, 4'd0, 1'b0}) begin
            fails++; $display("FAIL p1_result: got rv=%b w=%b s=%0d/%0d act=%b want 1 01 1/0 0",
                              result_valid, winner, score1, score2, round_active);
        end
        tick();
        checks++;
        if ({result_valid, round_active, game_over, winner, score1} !== {3'b000, 2'b01, 4'd1}) begin
            fails++; $display("FAIL p1_idle: got rv=%b act=%b go=%b w=%b s1=%0d want 0 0 0 01 1",
                              result_valid, round_active, game_over, winner, score1);
        end
    endtask

    task automatic test_lockout();
        do_reset();
        checks++;
        if ({score1, score2} !== 8'h00) begin
            fails++; $display("FAIL lock_reset_scores: got %0d/%0d want 0/0", score1, score2);
        end
        start_round();
        checks++;
        if ({op_a, op_b} !== {8'h61, 8'h2C}) begin
            fails++; $display("FAIL lock_ops: got %h/%h want 61/2C", op_a, op_b);
        end
        go2 = 1'b1; guess2 = 8'h8C;
        tick();
        go2 = 1'b0;
        checks++;
        if ({lock1, lock2, round_active, result_valid} !== 4'b0110) begin
            fails++; $display("FAIL lock_p2: got %b want 0110", {lock1, lock2, round_active, result_valid});
        end
        tick();
        // Locked P2 now answers correctly too; only P1 may count.
        go1 = 1'b1; guess1 = 8'h8D; go2 = 1'b1; guess2 = 8'h8D;
        tick();
        go1 = 1'b0; go2 = 1'b0;
        checks++;
        if ({result_valid, winner, score1, score2} !== {1'b1, 2'b01, 4'd1, 4'd0}) begin
            fails++; $display("FAIL lock_p1_wins: got rv=%b w=%b s=%0d/%0d want 1 01 1/0",
                              result_valid, winner, score1, score2);
        end
        tick();
    endtask

    task automatic test_draw();
        do_reset();
        start_round();
        go1 = 1'b1; guess1 = 8'h8D; go2 = 1'b1; guess2 = 8'h8D;
        tick();
        go1 = 1'b0; go2 = 1'b0;
        checks++;
        if ({result_valid, winner, score1, score2} !== {1'b1, 2'b11, 4'd0, 4'd0}) begin
            fails++; $display("FAIL draw: got rv=%b w=%b s=%0d/%0d want 1 11 0/0",
                              result_valid, winner, score1, score2);
        end
        tick();
    endtask

    task automatic test_both_wrong();
        start_round();
        checks++;
        if ({op_a, op_b, lock1, lock2} !== {8'h43, 8'h59, 2'b00}) begin
            fails++; $display("FAIL wrong_ops: got %h/%h locks=%b%b want 43/59 00", op_a, op_b, lock1, lock2);
        end
        go1 = 1'b1; guess1 = 8'h00;
        tick();
        go1 = 1'b0;
        checks++;
        if ({lock1, lock2, round_active} !== 3'b101) begin
            fails++; $display("FAIL wrong_p1: got %b want 101", {lock1, lock2, round_active});
        end
        go2 = 1'b1; guess2 = 8'h00;
        tick();
        go2 = 1'b0;
        checks++;
        if ({result_valid, winner, lock1, lock2, score1, score2} !== {1'b1, 2'b00, 2'b11, 8'h00}) begin
            fails++; $display("FAIL wrong_end: got rv=%b w=%b l=%b%b s=%0d/%0d want 1 00 11 0/0",
                              result_valid, winner, lock1, lock2, score1, score2);
        end
        tick();
    endtask

    task automatic test_timeout();
        start_round();
        checks++;
        if ({op_a, op_b, lock1, lock2, winner} !== {8'h07, 8'h33, 4'b0000}) begin
            fails++; $display("FAIL to_ops: got %h/%h l=%b%b w=%b want 07/33 00 00",
                              op_a, op_b, lock1, lock2, winner);
        end
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if ({round_active, result_valid} !== 2'b10) begin
                fails++; $display("FAIL to_wait%0d: got act=%b rv=%b want 1 0", i, round_active, result_valid);
            end
        end
        tick();
        checks++;
        if ({result_valid, winner, round_active} !== 4'b1000) begin
            fails++; $display("FAIL to_expire: got rv=%b w=%b act=%b want 1 00 0", result_valid, winner, round_active);
        end
        tick();
    endtask

    task automatic test_guess_beats_timeout();
        start_round();
        checks++;
        if ({op_a, op_b} !== {8'h0F, 8'h67}) begin
            fails++; $display("FAIL gbt_ops: got %h/%h want 0F/67", op_a, op_b);
        end
        repeat (3) tick();
        go2 = 1'b1; guess2 = 8'h76;
        tick();
        go2 = 1'b0;
        checks++;
        if ({result_valid, winner, score1, score2} !== {1'b1, 2'b10, 4'd0, 4'd1}) begin
            fails++; $display("FAIL gbt_result: got rv=%b w=%b s=%0d/%0d want 1 10 0/1",
                              result_valid, winner, score1, score2);
        end
        tick();
        checks++;
        if ({game_over, round_active} !== 2'b00) begin
            fails++; $display("FAIL gbt_idle: got go=%b act=%b want 0 0", game_over, round_active);
        end
    endtask

    task automatic test_game_over();
        start_round();
        checks++;
        if ({op_a, op_b} !== {8'h1E, 8'h4E}) begin
            fails++; $display("FAIL go_ops: got %h/%h want 1E/4E", op_a, op_b);
        end
        go2 = 1'b1; guess2 = 8'h6C;
        tick();
        go2 = 1'b0;
        checks++;
        if ({result_valid, winner, score2} !== {1'b1, 2'b10, 4'd2}) begin
            fails++; $display("FAIL go_win: got rv=%b w=%b s2=%0d want 1 10 2", result_valid, winner, score2);
        end
        repeat (2) tick();
        checks++;
        if ({game_over, round_active, score1, score2} !== {2'b10, 4'd0, 4'd2}) begin
            fails++; $display("FAIL go_hold: got go=%b act=%b s=%0d/%0d want 1 0 0/2",
                              game_over, round_active, score1, score2);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({game_over, round_active, score1, score2} !== {2'b00, 8'h00}) begin
            fails++; $display("FAIL go_restart: got go=%b act=%b s=%0d/%0d want 0 0 0/0",
                              game_over, round_active, score1, score2);
        end
        tick();
        checks++;
        if ({round_active, op_a, op_b} !== {1'b1, 8'h3C, 8'h1C}) begin
            fails++; $display("FAIL go_newround: got act=%b %h/%h want 1 3C/1C", round_active, op_a, op_b);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({round_active, result_valid, op_a} !== {2'b10, 8'h3C}) begin
            fails++; $display("FAIL go_start_ignored: got act=%b rv=%b a=%h want 1 0 3C",
                              round_active, result_valid, op_a);
        end
    endtask

    task automatic test_err();
        force_cout = 1'b1;
        go1 = 1'b1; guess1 = 8'h58;
        tick();
        force_cout = 1'b0; go1 = 1'b0;
        checks++;
        if ({result_valid, winner, err, score1, score2} !== {1'b1, 2'b00, 1'b1, 8'h00}) begin
            fails++; $display("FAIL err_round: got rv=%b w=%b err=%b s=%0d/%0d want 1 00 1 0/0",
                              result_valid, winner, err, score1, score2);
        end
        tick();
        checks++;
        if ({err, round_active} !== 2'b10) begin
            fails++; $display("FAIL err_sticky: got err=%b act=%b want 1 0", err, round_active);
        end
        start_round();
        checks++;
        if ({err, op_a, op_b} !== {1'b0, 8'h79, 8'h38}) begin
            fails++; $display("FAIL err_cleared: got err=%b %h/%h want 0 79/38", err, op_a, op_b);
        end
        go1 = 1'b1; guess1 = 8'hB1;
        tick();
        go1 = 1'b0;
        checks++;
        if ({winner, score1} !== {2'b01, 4'd1}) begin
            fails++; $display("FAIL err_next_win: got w=%b s1=%0d want 01 1", winner, score1);
        end
        tick();
    endtask

    task automatic test_reset_mid_round();
        start_round();
        checks++;
        if ({op_a, op_b} !== {8'h72, 8'h70}) begin
            fails++; $display("FAIL mid_ops: got %h/%h want 72/70", op_a, op_b);
        end
        go1 = 1'b1; guess1 = 8'h00;
        tick();
        go1 = 1'b0;
        rst_n = 1'b0;
        #2;
        checks++;
        if ({op_a, op_b, op_cin, score1, score2} !== 25'h0) begin
            fails++; $display("FAIL mid_reset_data: got %h/%h cin=%b s=%0d/%0d want 00/00 0 0/0",
                              op_a, op_b, op_cin, score1, score2);
        end
        checks++;
        if ({lock1, lock2, winner, err, result_valid, round_active, game_over} !== 8'h00) begin
            fails++; $display("FAIL mid_reset_flags: got %b want 00000000",
                              {lock1, lock2, winner, err, result_valid, round_active, game_over});
        end
        #1;
        rst_n = 1'b1;
        start_round();
        checks++;
        if ({round_active, op_a, op_b} !== {1'b1, 8'h61, 8'h2C}) begin
            fails++; $display("FAIL mid_reseed: got act=%b %h/%h want 1 61/2C", round_active, op_a, op_b);
        end
    endtask

    initial begin
        test_reset();
        test_p1_win();
        test_lockout();
        test_draw();
        test_both_wrong();
        test_timeout();
        test_guess_beats_timeout();
        test_game_over();
        test_err();
        test_reset_mid_round();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
